// File: rtl/fl_if.sv
// -----------------------------------------------------------------------------
// fl_if : rename-stage <-> free-list bundle.
//   master (ROB / rename side) drives dispatch and retire requests and reads
//   the two head tags, their valids, the free count and the sticky error flag.
//   slave  (free list) is the reverse.
// Build option: FL_RECOVER_EN adds rob_recover (master -> slave).
// -----------------------------------------------------------------------------
interface fl_if #(
    parameter int PR_WIDTH = 7,
    parameter int CNT_W    = 6
);
    logic [1:0]          rob_dispatch_num;
    logic [1:0]          rob_retire_num;
    logic [PR_WIDTH-1:0] rob_retire_told0;
    logic [PR_WIDTH-1:0] rob_retire_told1;
`ifdef FL_RECOVER_EN
    logic                rob_recover;
`endif
    logic [PR_WIDTH-1:0] fl_pr0;
    logic [PR_WIDTH-1:0] fl_pr1;
    logic                fl_pr0_valid;
    logic                fl_pr1_valid;
    logic [CNT_W-1:0]    fl_num_free;
    logic                fl_error;

`ifdef FL_RECOVER_EN
    modport master (
        output rob_dispatch_num, rob_retire_num, rob_retire_told0, rob_retire_told1, rob_recover,
        input  fl_pr0, fl_pr1, fl_pr0_valid, fl_pr1_valid, fl_num_free, fl_error
    );
    modport slave (
        input  rob_dispatch_num, rob_retire_num, rob_retire_told0, rob_retire_told1, rob_recover,
        output fl_pr0, fl_pr1, fl_pr0_valid, fl_pr1_valid, fl_num_free, fl_error
    );
`else
    modport master (
        output rob_dispatch_num, rob_retire_num, rob_retire_told0, rob_retire_told1,
        input  fl_pr0, fl_pr1, fl_pr0_valid, fl_pr1_valid, fl_num_free, fl_error
    );
    modport slave (
        input  rob_dispatch_num, rob_retire_num, rob_retire_told0, rob_retire_told1,
        output fl_pr0, fl_pr1, fl_pr0_valid, fl_pr1_valid, fl_num_free, fl_error
    );
`endif
endinterface

// File: rtl/fl.sv
// -----------------------------------------------------------------------------
// fl : physical-register free list for a 2-wide R10K-style rename stage.
//   Circular FIFO of FL_DEPTH tags. Up to two tags are handed out per cycle
//   (fl_pr0/fl_pr1, read straight from the head, zero-cycle latency) and up to
//   two stale tags (Told) are written back at the tail per cycle.
// Ports:
//   clock  - posedge clock
//   reset  - asynchronous, active-low
//   bus    - fl_if.slave: dispatch/retire requests in; head tags, valids,
//            free count and sticky error flag out
// Build option: FL_RECOVER_EN adds bus.rob_recover and an architectural head
//   pointer; a recover rewinds head to it and marks the list full again.
// -----------------------------------------------------------------------------
module fl #(
    parameter int PR_NUM   = 64,
    parameter int AR_NUM   = 32,
    parameter int PR_WIDTH = 7,
    parameter int FL_DEPTH = PR_NUM - AR_NUM
) (
    input  logic clock,
    input  logic reset,
    fl_if.slave  bus
);
    localparam int PTR_W = $clog2(FL_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CW1   = CNT_W + 1;

    logic [PR_WIDTH-1:0] entry [FL_DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count;
    logic                error;

    logic [1:0]          d, r, d_eff, r_eff;
    logic                d_ok, r_ok, rec;
    logic [CW1-1:0]      after_alloc, after_free;
    logic [PTR_W-1:0]    head_p1, tail_p1;

`ifdef FL_RECOVER_EN
    logic [PTR_W-1:0]    arch_head, arch_head_nxt;
    assign rec           = bus.rob_recover;
    assign arch_head_nxt = arch_head + PTR_W'(r_eff);
`else
    assign rec = 1'b0;
`endif

    always_comb begin
        d = bus.rob_dispatch_num;
        r = bus.rob_retire_num;
        // A recover cancels dispatch outright, so it is neither applied nor an error.
        d_ok        = (d != 2'd3) && (CNT_W'(d) <= count);
        d_eff       = (d_ok && !rec) ? d : 2'd0;
        // Free legality is judged after the (legal) allocation of the same cycle.
        after_alloc = {1'b0, count} - CW1'(d_eff);
        r_ok        = (r != 2'd3) && ((after_alloc + CW1'(r)) <= CW1'(FL_DEPTH));
        r_eff       = r_ok ? r : 2'd0;
        after_free  = after_alloc + CW1'(r_eff);
    end

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++) entry[i] <= PR_WIDTH'(AR_NUM + i);
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FL_DEPTH);
            error <= 1'b0;
`ifdef FL_RECOVER_EN
            arch_head <= '0;
`endif
        end else begin
            if (r_eff != 2'd0) entry[tail]    <= bus.rob_retire_told0;
            if (r_eff == 2'd2) entry[tail_p1] <= bus.rob_retire_told1;
            tail  <= tail + PTR_W'(r_eff);
            error <= error | (!d_ok && !rec) | !r_ok;
`ifdef FL_RECOVER_EN
            arch_head <= arch_head_nxt;
            if (rec) begin
                head  <= arch_head_nxt;
                count <= CNT_W'(FL_DEPTH);
            end else begin
                head  <= head + PTR_W'(d_eff);
                count <= after_free[CNT_W-1:0];
            end
`else
            head  <= head + PTR_W'(d_eff);
            count <= after_free[CNT_W-1:0];
`endif
        end
    end

    // Outputs read registered state only: a tag written this cycle is not
    // bypassed to the head ports.
    assign bus.fl_pr0       = entry[head];
    assign bus.fl_pr1       = entry[head_p1];
    assign bus.fl_pr0_valid = (count != '0);
    assign bus.fl_pr1_valid = (count > CNT_W'(1));
    assign bus.fl_num_free  = count;
    assign bus.fl_error     = error;
endmodule

// File: tb/tb_fl.sv
// -----------------------------------------------------------------------------
// tb_fl : randomized self-checking bench for fl against a queue model of the
//   free list (pop from front on allocate, push to back on free).
// -----------------------------------------------------------------------------
module tb_fl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fl_if bus();
    fl dut (.clock(clock), .reset(reset), .bus(bus.slave));

    int npass = 0;
    int ntot  = 0;
    int q[$];
    bit merr;

    task automatic chk(input string tag, input int got, input int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        q = {};
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
        merr = 1'b0;
    endtask

    task automatic check_model(input string ph);
        chk({ph, ":num_free"}, int'(bus.fl_num_free), q.size());
        chk({ph, ":v0"}, int'(bus.fl_pr0_valid), int'(q.size() >= 1));
        chk({ph, ":v1"}, int'(bus.fl_pr1_valid), int'(q.size() >= 2));
        chk({ph, ":err"}, int'(bus.fl_error), int'(merr));
        if (q.size() >= 1) chk({ph, ":pr0"}, int'(bus.fl_pr0), q[0]);
        if (q.size() >= 2) chk({ph, ":pr1"}, int'(bus.fl_pr1), q[1]);
    endtask

    // One cycle of requests; model applied with the spec's legality rules.
    task automatic step(input string ph, input int d, input int r, input int t0, input int t1);
        int c, de;
        bit dl, rl;
        bus.rob_dispatch_num = 2'(d);
        bus.rob_retire_num   = 2'(r);
        bus.rob_retire_told0 = 7'(t0);
        bus.rob_retire_told1 = 7'(t1);
        @(posedge clock);
        c  = q.size();
        dl = (d <= 2) && (d <= c);
        de = dl ? d : 0;
        rl = (r <= 2) && (c - de + r <= 32);
        if (!dl || !rl) merr = 1'b1;
        repeat (de) void'(q.pop_front());
        if (rl && r >= 1) q.push_back(t0);
        if (rl && r == 2) q.push_back(t1);
        @(negedge clock);
        bus.rob_dispatch_num = 2'd0;
        bus.rob_retire_num   = 2'd0;
        check_model(ph);
    endtask

    // Reset asserted mid-cycle while a dispatch is in flight.
    task automatic do_reset();
        bus.rob_dispatch_num = 2'd2;
        bus.rob_retire_num   = 2'd1;
        @(posedge clock);
        #2 reset = 1'b0;
        bus.rob_dispatch_num = 2'd0;
        bus.rob_retire_num   = 2'd0;
        #1 model_reset();
        check_model("async_rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int d, r;
        bus.rob_dispatch_num = 2'd0;
        bus.rob_retire_num   = 2'd0;
        bus.rob_retire_told0 = '0;
        bus.rob_retire_told1 = '0;
`ifdef FL_RECOVER_EN
        bus.rob_recover = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_model("idle");
        chk("rst_pr0", int'(bus.fl_pr0), 32);
        chk("rst_pr1", int'(bus.fl_pr1), 33);
        chk("rst_free", int'(bus.fl_num_free), 32);

        for (int i = 0; i < 3; i++) begin
            step("disp2", 2, 0, 0, 0);
            chk("disp2_pr0", int'(bus.fl_pr0), 34 + 2 * i);
            chk("disp2_free", int'(bus.fl_num_free), 30 - 2 * i);
        end
        for (int i = 0; i < 13; i++) step("drain", 2, 0, 0, 0);
        step("underflow", 1, 0, 0, 0);
        chk("uf_v0", int'(bus.fl_pr0_valid), 0);
        chk("uf_err", int'(bus.fl_error), 1);
        step("refill_empty", 0, 2, 3, 4);
        chk("re_pr0", int'(bus.fl_pr0), 3);
        chk("re_pr1", int'(bus.fl_pr1), 4);
        step("simul", 2, 2, 5, 6);
        chk("sim_pr0", int'(bus.fl_pr0), 5);
        chk("sim_pr1", int'(bus.fl_pr1), 6);
        chk("sim_free", int'(bus.fl_num_free), 2);

        do_reset();
        step("overflow", 0, 1, 9, 0);
        chk("of_free", int'(bus.fl_num_free), 32);
        chk("of_err", int'(bus.fl_error), 1);

        // Alternating drain/refill phases so empty, full and wrap are all hit.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (((i / 40) % 2) == 0) begin
                d = int'($urandom_range(1, 2));
                r = int'($urandom_range(0, 1));
            end else begin
                d = int'($urandom_range(0, 1));
                r = int'($urandom_range(1, 2));
            end
            if ($urandom_range(0, 39) == 0) d = 3;
            if ($urandom_range(0, 39) == 0) r = 3;
            step("rand", d, r, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
        end

`ifdef FL_RECOVER_EN
        do_reset();
        step("rec_a", 2, 0, 0, 0);
        step("rec_b", 2, 0, 0, 0);
        step("rec_c", 0, 1, 7, 0);
        bus.rob_recover      = 1'b1;
        bus.rob_dispatch_num = 2'd2;
        @(posedge clock);
        @(negedge clock);
        bus.rob_recover      = 1'b0;
        bus.rob_dispatch_num = 2'd0;
        chk("rec_free", int'(bus.fl_num_free), 32);
        chk("rec_pr0", int'(bus.fl_pr0), 33);
        chk("rec_err", int'(bus.fl_error), 0);
        do_reset();
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/fl.md
Name: fl

Overview:
- Physical-register free list for the 2-wide R10K-style rename stage.
- Supplies the two next free physical tags (fl_pr0, fl_pr1) to the map table and ROB at dispatch.
- Reclaims the stale tags (Told) that the ROB releases at retirement.
- Circular FIFO of PR_NUM-AR_NUM 7-bit tags with 0/1/2 allocations and 0/1/2 frees per cycle.

Parameters:
PR_NUM, 64, number of physical registers
AR_NUM, 32, number of architectural registers (PR 0..AR_NUM-1 are architecturally mapped at reset)
PR_WIDTH, 7, physical tag width
FL_DEPTH, PR_NUM-AR_NUM (32), free-list entries; power of two

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset
rob_dispatch_num  input  2  tags consumed this cycle (0, 1 or 2; 3 is illegal)
rob_retire_num  input  2  tags freed this cycle (0, 1 or 2; 3 is illegal)
rob_retire_told0  input  PR_WIDTH  first freed tag, used when rob_retire_num>=1
rob_retire_told1  input  PR_WIDTH  second freed tag, used when rob_retire_num==2
fl_pr0  output  PR_WIDTH  entry at head
fl_pr1  output  PR_WIDTH  entry at head+1 (mod FL_DEPTH)
fl_pr0_valid  output  1  fl_num_free>=1
fl_pr1_valid  output  1  fl_num_free>=2
fl_num_free  output  6  current free count, 0..FL_DEPTH
fl_error  output  1  sticky illegal-request flag

Behaviour:
- State: entry[0..FL_DEPTH-1], head (5b), tail (5b), count (6b), error (1b). All pointer arithmetic is modulo FL_DEPTH.
- Reset (reset==0, asynchronous):
  - entry[i]=AR_NUM+i; head=0; tail=0; count=FL_DEPTH; error=0.
  - Resulting outputs: fl_pr0=32, fl_pr1=33, both valids 1, fl_num_free=32, fl_error=0.
- All outputs decode registered state combinationally. Zero-cycle read latency: a tag shown in cycle N is the one consumed if dispatch occurs in cycle N.
- Allocation (posedge):
  - d=rob_dispatch_num.
  - Legal if d<=2 and d<=count. If legal: head+=d.
  - Entry contents are untouched by allocation.
- Free (posedge):
  - r=rob_retire_num.
  - Legal if r<=2 and count-d_eff+r<=FL_DEPTH, where d_eff is 0 when the dispatch is illegal.
  - If legal: entry[tail]=told0 (r>=1), entry[tail+1]=told1 (r==2), tail+=r.
- Count update: count_next=count-d_eff+r_eff.
- Simultaneous allocate and free in the same cycle are both applied.
  - A freed tag is never visible on fl_pr0/fl_pr1 in the cycle it is written (no bypass). It becomes visible at the earliest one cycle later.
  - Exception: with count==0 and r==2, d==0, both tags appear next cycle as fl_pr0 and fl_pr1, in order told0 then told1.
- Illegal request (either field ==3, underflow, or overflow):
  - The offending operation is dropped entirely; the other operation still applies if it is legal on its own.
  - error is set and held until reset.
- Full (count==32): head==tail. Empty (count==0): head==tail, both valids 0. count alone disambiguates the two.
- Wrap-around: pointer 31+1 becomes 0; fl_pr1 reads entry[0] when head==31.
- Reset mid-operation: all in-flight pointers and entries are discarded immediately.

Optional Feature:
Macro FL_RECOVER_EN.
- Defined:
  - Adds input rob_recover (1 bit) and an internal retire-head pointer arch_head (reset 0).
  - arch_head+=r_eff on every legal free.
  - When rob_recover==1 at posedge: frees of that cycle are applied first; then head=arch_head_next, count=FL_DEPTH, and dispatch of that cycle is ignored without setting error.
  - This returns every speculatively allocated tag to the list.
- Not defined: the port and arch_head are absent; there is no recovery path.

Test Plan:
- Reset release, no activity -> fl_pr0=32, fl_pr1=33, fl_num_free=32, both valids 1, fl_error=0.
- dispatch_num=2 for 3 cycles -> outputs 34/35, then 36/37, then 38/39; fl_num_free 30, 28, 26.
- Drain all 32 via dispatch_num=2; then dispatch_num=1 -> valids 0, fl_num_free stays 0, fl_error=1. Next cycle retire_num=2 with told0=3, told1=4 -> fl_pr0=3, fl_pr1=4, fl_num_free=2.
- Simultaneous dispatch_num=2 and retire_num=2 (told 5, 6) at fl_num_free=2 -> fl_num_free=2, fl_pr0=5, fl_pr1=6 next cycle.
- Retire_num=1 while full -> dropped, fl_num_free=32, fl_error=1.
- FL_RECOVER_EN: dispatch 4 tags (32..35), retire 1 (told=7), then rob_recover=1 -> fl_num_free=32, fl_pr0=33 (head=arch_head=1).
